// File: rtl/or_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined OR-reduction tree.
package or_reduce_pkg;

  localparam logic OR_MODE_PASS   = 1'b0;
  localparam logic OR_MODE_STICKY = 1'b1;

  // Output width of tree level `lvl` (lvl = -1 gives the raw input width n).
  function automatic int or_group_cnt(input int n, input int fanin, input int lvl);
    int w;
    w = n;
    for (int i = 0; i <= lvl; i++) begin
      w = (w + fanin - 1) / fanin;
    end
    return w;
  endfunction

  // Number of registered OR levels needed to bring n bits down to one; at least one.
  function automatic int or_levels(input int n, input int fanin);
    int w;
    int l;
    w = (n + fanin - 1) / fanin;
    l = 1;
    while (w > 1) begin
      w = (w + fanin - 1) / fanin;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One registered OR level for all lanes: groups of FANIN bits per lane are ORed
// (last group may be short), optionally merged with a mask, and held with a valid
// and mode bit. The stage accepts a new beat when empty or when it drains this cycle.
module or_reduce_stage
  import or_reduce_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W_IN  = 8,
  parameter int FANIN = 3,
  parameter int W_OUT = or_group_cnt(W_IN, FANIN, 0)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*W_IN-1:0]  data_i,
  input  logic                   valid_i,
  input  logic                   mode_i,
  input  logic [LANES*W_OUT-1:0] mask_i,
  input  logic                   ready_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic                   mode_o,
  output logic [LANES*W_OUT-1:0] data_o
);

  logic [LANES*W_OUT-1:0] res;
  logic [LANES*W_OUT-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   mode_q, mode_d;
  logic                   load;

  assign ready_o = !valid_q || ready_i;
  assign load    = valid_i && ready_o;

  // Group-wise OR of each lane's input bits, merged with the caller's mask.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int b = 0; b < W_IN; b++) begin
        res[k*W_OUT + b/FANIN] |= data_i[k*W_IN + b];
      end
    end
    res |= mask_i;
  end

  // Next-state: load on acceptance, empty when the contents leave without a refill.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = res;
      mode_d  = mode_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Stage register; reset discards any beat in flight.
  // NOTE: state registers use non-blocking assignment so all stages update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= OR_MODE_PASS;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined OR-reduction of N_IN bits per lane over LANES lanes with valid/ready
// flow control. The final level merges the sticky accumulator for sticky beats;
// ACC tracks the last sticky result and is zeroed by CLR (clear wins over the merge).
module or_reduce_pipe
  import or_reduce_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int LANES = 4,
  parameter int FANIN = 3
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic [LANES*N_IN-1:0] IN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  MODE,
  input  logic                  CLR,
  output logic [LANES-1:0]      Q,
  output logic                  Q_VALID,
  input  logic                  Q_READY
);

  localparam int L = or_levels(N_IN, FANIN);

  logic [L-1:0]     stage_valid;
  logic [L-1:0]     stage_mode;
  logic [L-1:0]     stage_ready;

  logic [LANES-1:0] acc_q, acc_d;
  logic [LANES-1:0] fin_tree;
  logic [LANES-1:0] fin_mask;
  logic             fin_load;
  logic             fin_sticky;

  assign IN_READY = stage_ready[0];

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int W_I = or_group_cnt(N_IN, FANIN, j - 1);
    localparam int W_O = or_group_cnt(N_IN, FANIN, j);

    logic [LANES*W_I-1:0] din;
    logic [LANES*W_O-1:0] dout;
    logic [LANES*W_O-1:0] mask;
    logic                 valid_in;
    logic                 mode_in;
    logic                 rdy_dn;

    if (j == 0) begin : g_head
      assign din      = IN;
      assign valid_in = IN_VALID;
      assign mode_in  = MODE;
    end else begin : g_link
      assign din      = g_lvl[j-1].dout;
      assign valid_in = stage_valid[j-1];
      assign mode_in  = stage_mode[j-1];
    end

    if (j == L - 1) begin : g_tail
      // The final stage's carried mode has no consumer beyond this point.
      logic mode_unused;
      assign mode_unused = stage_mode[j];
      assign rdy_dn      = Q_READY;
      assign fin_sticky  = (mode_in == OR_MODE_STICKY);
      assign fin_load    = valid_in && stage_ready[j];
      assign fin_mask    = (fin_sticky && !CLR) ? acc_q : '0;
      assign mask        = fin_mask;
      assign Q           = dout;
      assign Q_VALID     = stage_valid[j];

      // Per-lane tree result entering the final stage, before the sticky merge.
      always_comb begin
        fin_tree = '0;
        for (int k = 0; k < LANES; k++) begin
          fin_tree[k] = |din[k*W_I +: W_I];
        end
      end
    end else begin : g_mid
      assign rdy_dn = stage_ready[j+1];
      assign mask   = '0;
    end

    or_reduce_stage #(
      .LANES (LANES),
      .W_IN  (W_I),
      .FANIN (FANIN),
      .W_OUT (W_O)
    ) u_stage (
      .clk     (CLK),
      .rst_n   (RSTB),
      .data_i  (din),
      .valid_i (valid_in),
      .mode_i  (mode_in),
      .mask_i  (mask),
      .ready_i (rdy_dn),
      .ready_o (stage_ready[j]),
      .valid_o (stage_valid[j]),
      .mode_o  (stage_mode[j]),
      .data_o  (dout)
    );
  end

  // ACC takes the merged value of each sticky beat entering the final stage; a CLR
  // without such a beat empties it (with one, the mask is already suppressed).
  always_comb begin
    acc_d = acc_q;
    if (fin_load && fin_sticky) begin
      acc_d = fin_tree | fin_mask;
    end else if (CLR) begin
      acc_d = '0;
    end
  end

  // Accumulator register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Self-checking bench: directed literal cases plus a randomized stream scored
// against a queue-based OR-reduce / sticky-accumulate model.
module tb_or_reduce_pipe;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] in_d = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  q;
  logic        q_valid;
  logic        q_ready = 1'b1;

  // Small configurations: N_IN=1 (one level) and N_IN=9 (two levels).
  logic [1:0]  in1 = '0;
  logic        v1 = 1'b0, r1, qv1;
  logic [1:0]  q1;
  logic [8:0]  in9 = '0;
  logic        v9 = 1'b0, r9, qv9;
  logic [0:0]  q9;
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  or_reduce_pipe #(.N_IN(8), .LANES(4), .FANIN(3)) dut (
    .CLK(clk), .RSTB(rstb), .IN(in_d), .IN_VALID(in_valid), .IN_READY(in_ready),
    .MODE(mode), .CLR(clr), .Q(q), .Q_VALID(q_valid), .Q_READY(q_ready)
  );

  or_reduce_pipe #(.N_IN(1), .LANES(2), .FANIN(2)) u_one (
    .CLK(clk), .RSTB(rstb), .IN(in1), .IN_VALID(v1), .IN_READY(r1),
    .MODE(tie0), .CLR(tie0), .Q(q1), .Q_VALID(qv1), .Q_READY(tie1)
  );

  or_reduce_pipe #(.N_IN(9), .LANES(1), .FANIN(3)) u_nine (
    .CLK(clk), .RSTB(rstb), .IN(in9), .IN_VALID(v9), .IN_READY(r9),
    .MODE(tie0), .CLR(tie0), .Q(q9), .Q_VALID(qv9), .Q_READY(tie1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a lane's result is 1 when any of its 8 input bits is set.
  function automatic logic [3:0] ref_or(input logic [31:0] d);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (d[k*8 +: 8] != 8'h00);
    return r;
  endfunction

  function automatic logic [31:0] rand_beat();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 2) == 0) d[k*8 + $urandom_range(0, 7)] = 1'b1;
    end
    return d;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [3:0] exp_q[$];
  logic [3:0] sb_acc = '0;
  logic [3:0] t_ref;
  logic [3:0] prev_q = '0;
  bit         prev_stall = 1'b0;
  bit         sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en && rstb) begin
      if (prev_stall) begin
        check("stall_hold_valid", q_valid, 1);
        check("stall_hold_q", q, prev_q);
      end
      if (q_ready) check("full_rate_in_ready", in_ready, 1);
      if (q_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", q_valid, 0);
        end else begin
          check("stream_q", q, exp_q[0]);
          if (q_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        t_ref = ref_or(in_d);
        if (mode) begin
          sb_acc = sb_acc | t_ref;
          exp_q.push_back(sb_acc);
        end else begin
          exp_q.push_back(t_ref);
        end
      end
      prev_stall = q_valid && !q_ready;
      prev_q     = q;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed helpers ----------------
  // Called #1 after a rising edge; returns #1 after the edge that accepts the beat.
  task automatic send(input logic [31:0] d, input logic m);
    int n;
    n = 0;
    in_d = d;
    mode = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a valid result with Q_READY=1 and checks it.
  task automatic get_out(input string name, input logic [3:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!q_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {q_valid, q}, {1'b1, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cb[4];
    logic [3:0]  ce[4];
    int idx, outs, sent;
    bit took;

    cb = '{32'h0000_0080, 32'h0000_4000, 32'h0020_0000, 32'h1000_0000};
    ce = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset state.
    #3;
    check("rst_q", q, 0);
    check("rst_q_valid", q_valid, 0);
    #9 rstb = 1'b1;
    @(negedge clk);
    check("post_rst_q", {q_valid, q}, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single pass beat: lanes {00,01,80,00} -> 0110, two stages of latency.
    in_d = 32'h0080_0100;
    mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("t1_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t1_not_yet", q_valid, 0);
    @(negedge clk);
    check("t1_q", {q_valid, q}, {1'b1, 4'b0110});
    @(negedge clk);
    check("t1_one_cycle", q_valid, 0);
    @(posedge clk);
    #1;

    // Small configurations: one-level pass-through and two-level N_IN=9.
    in1 = 2'b10; v1 = 1'b1;
    in9 = 9'h100; v9 = 1'b1;
    @(negedge clk);
    check("one_accept", r1, 1);
    check("nine_accept", r9, 1);
    @(posedge clk);
    #1 v1 = 1'b0; v9 = 1'b0;
    @(negedge clk);
    check("one_q", {qv1, q1}, 3'b110);
    check("nine_not_yet", qv9, 0);
    @(negedge clk);
    check("nine_q", {qv9, q9}, 2'b11);
    check("one_drained", qv1, 0);
    @(posedge clk);
    #1;

    // Sticky accumulation, then CLR coinciding with a sticky beat's final load.
    send(32'h0000_0001, 1'b1); get_out("st_0001", 4'b0001);
    send(32'h0001_0000, 1'b1); get_out("st_0101", 4'b0101);
    send(32'h0000_0000, 1'b1); get_out("st_hold", 4'b0101);
    send(32'h0100_0000, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    get_out("st_clr_beat", 4'b1000);
    send(32'h0000_0100, 1'b0); get_out("pass_beat", 4'b0010);
    send(32'h0000_0000, 1'b1); get_out("acc_after_clr", 4'b1000);

    // Capacity under backpressure, then in-order release.
    q_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      in_d = cb[idx % 4];
      mode = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("cap_accepted", idx, 2);
    @(negedge clk);
    check("cap_in_ready_low", in_ready, 0);
    check("cap_head_held", {q_valid, q}, {1'b1, 4'b0001});
    @(posedge clk);
    #1 q_ready = 1'b1;
    outs = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 4);
      in_d = cb[idx % 4];
      @(negedge clk);
      if (q_valid && q_ready) begin
        if (outs < 4) check("cap_order", q, ce[outs]);
        else check("cap_duplicate", q_valid, 0);
        outs++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("cap_out_count", outs, 4);

    // Mid-stream reset with ACC full and two beats in flight.
    send(32'h0101_0101, 1'b1); get_out("rst_acc_full", 4'b1111);
    q_ready = 1'b0;
    send(32'h0000_0001, 1'b1);
    send(32'h0000_0001, 1'b1);
    #2 rstb = 1'b0;
    #1;
    check("mid_rst_q", {q_valid, q}, 0);
    #3 rstb = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_empty", q_valid, 0);
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0000_0001, 1'b1); get_out("rst_sticky_fresh", 4'b0001);

    // Randomized stream against the scoreboard; ACC emptied first.
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    sb_acc = '0;
    exp_q.delete();
    sb_en = 1'b1;
    sent = 0;
    took = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 2000 && sent < 64; c++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_d = rand_beat();
        mode = $urandom_range(0, 1);
      end
      q_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sent++;
      @(posedge clk);
      #1;
      if (took && sent >= 64) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    q_ready = 1'b1;
    check("rand_beats_sent", sent, 64);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rand_drained", exp_q.size(), 0);
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
